mul_div_unit: RTL and testbench
===============================

# mul_div_unit

- Parametrised multi-cycle multiply/divide unit owning the architectural HI/LO registers.
- Successor to the single-cycle HI/LO logic inside the ALU; the ALU forwards MULT/MULTU/DIV/DIVU/MTHI/MTLO here.
- Divide is iterative at one quotient bit per cycle. Multiply latency is configurable. A busy/done handshake lets the control unit stall MFHI/MFLO.
- Divide-by-zero and signed overflow produce defined results. An in-flight operation can be flushed.

## Interface
- WIDTH, 32, operand and HI/LO width; any even value ≥ 4.
- MUL_LAT, 2, multiply latency in cycles (≥ 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- op  in  3  mdu_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
- a  in  WIDTH  operand 1 (rs); the MTHI/MTLO source
- b  in  WIDTH  operand 2 (rt)
- flush  in  1  cancels any in-flight operation
- busy  out  1  operation in flight; HI/LO not yet valid
- done  out  1  single-cycle pulse on the cycle after HI/LO update from MULT/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- State machine (mdu_state_t): IDLE, MUL, DIV, FIX.
- Reset: state=IDLE; hi=0; lo=0; busy=0; done=0; internal counters=0.
- **IDLE**
  - start with MTHI: hi<=a at that edge; no busy, no done.
  - start with MTLO: lo<=a at that edge; no busy, no done.
  - start with MULT/MULTU:
    - Captures the full 2·WIDTH product: signed×signed or unsigned×unsigned.
    - Loads count=MUL_LAT-1; goes to MUL.
  - start with DIV/DIVU:
    - Latches operand magnitudes and sign flags (sign flags are zero for DIVU).
    - Loads count=WIDTH-1; goes to DIV.
- **MUL**: count decrements each cycle. At count=0: {hi,lo}<=product, done<=1, go to IDLE.
- **DIV**: restoring step each cycle.
  - remainder = {remainder[WIDTH-2:0], dividend MSB} − divisor.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - At count=0, go to FIX.
- **FIX**: writes hi/lo, pulses done, goes to IDLE.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend, giving truncating division.
  - b=0: lo=all ones, hi=a, for signed and unsigned alike.
  - Signed a=MIN, b=−1: lo=MIN, hi=0.
- **start while busy=1**: ignored, with no effect on the operation in progress. Control must hold off issuing.
- **flush**:
  - Has priority over everything, including completion in the same cycle.
  - Returns to IDLE next edge; hi/lo unchanged; done stays 0.
  - flush with start in IDLE: the start is dropped.
- rst_n assertion mid-operation aborts immediately, with all outputs at reset values.

## Timing
- Edge E0 samples start=1. busy is high from after E0.
- MULT: hi/lo valid and done=1 after edge E_MUL_LAT. busy falls after the same edge.
- DIV: WIDTH iteration edges plus one FIX edge. Results and done appear after E_(WIDTH+1), i.e. 33 cycles for WIDTH=32.
  - Latency is fixed, including for b=0 and overflow.
- done is high exactly one cycle. A new start is accepted in the same cycle done is high, since busy=0.
- MTHI/MTLO: visible on hi/lo one edge after start. Back-to-back MTHI then MTLO is allowed on consecutive cycles.
- hi/lo are registered outputs. No combinational path from inputs to any output.

## Structure
- mdu_pkg holds:
  - mdu_op_t, 3-bit enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6–7 are treated as no-op.
  - mdu_state_t.
- Sub-module mdu_divider:
  - Unsigned WIDTH-bit iterative restoring core.
  - Ports: load, step, dividend, divisor; outputs quotient, remainder.
  - Sign handling and the FIX state stay in mul_div_unit.
- The multiplier is an inferred signed (WIDTH+1)-bit product, sign- or zero-extending each operand per op, registered once, then delayed by the counter.

## Test plan
All scenarios use WIDTH=32, MUL_LAT=2.
- MULT a=0xFFFFFFFF, b=2 -> after 2 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, done for one cycle. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=−7, b=2 -> after 33 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Both take 33 cycles.
- MTHI a=0x1234 then MTLO a=0x5678 on the next cycle -> hi=0x1234, lo=0x5678, busy never asserted. A start issued while DIV is busy is ignored and the DIV result is correct.
- Preload hi=lo=0xAA via MTHI/MTLO. Start DIV, assert flush at cycle 10 -> busy=0 next cycle, no done, hi=lo=0xAA.
- Deassert rst_n at cycle 5 of a MULT/DIV -> all outputs 0 immediately. After release, a new MULTU 3×4 yields hi=0, lo=12.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: forwarded op codes and FSM states.
package mdu_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  // Prefixed so that DIV/MUL do not collide with the op literals above.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit_divider.sv
// Unsigned iterative restoring divider core: one quotient bit per step.
// The dividend shifts out of the quotient register as quotient bits shift in.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   trial_s;

  // Next-state for one restoring iteration, or a fresh load.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    // Trial is one bit wider: the shifted remainder can exceed WIDTH bits for large divisors.
    trial_s = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (load) begin
      rem_d = {WIDTH{1'b0}};
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      if (!trial_s[WIDTH]) begin
        rem_d = trial_s[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_d = rem_q;
    end
  end

  // Divider working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= {WIDTH{1'b0}};
      quo_q <= {WIDTH{1'b0}};
      dvs_q <= {WIDTH{1'b0}};
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO, with busy/done handshake and flush.
// Multiply is one registered product delayed by a counter; divide uses mdu_divider.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  mdu_state_t         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;

  mdu_op_t                   op_s;
  logic                      is_signed_s;
  logic signed [WIDTH:0]     ma_s, mb_s;
  logic signed [2*WIDTH+1:0] prod_full_s;
  logic [1:0]                unused_prod_s;
  logic [WIDTH-1:0]          a_mag_s, b_mag_s;
  logic [WIDTH-1:0]          quo_s, rem_s;
  logic [WIDTH-1:0]          lo_fix_s, hi_fix_s;
  logic                      div_load_s, div_step_s;

  assign op_s        = mdu_op_t'(op);
  assign is_signed_s = (op_s == MULT) || (op_s == DIV);
  assign ma_s        = {is_signed_s & a[WIDTH-1], a};
  assign mb_s        = {is_signed_s & b[WIDTH-1], b};
  assign prod_full_s = ma_s * mb_s;
  assign unused_prod_s = prod_full_s[2*WIDTH+1:2*WIDTH];
  assign a_mag_s     = (is_signed_s && a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign b_mag_s     = (is_signed_s && b[WIDTH-1]) ? (~b + ONE_W) : b;
  // Truncating division: quotient sign from the XOR of signs, remainder follows the dividend.
  assign lo_fix_s    = neg_quo_q ? (~quo_s + ONE_W) : quo_s;
  assign hi_fix_s    = neg_rem_q ? (~rem_s + ONE_W) : rem_s;

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load_s),
    .step      (div_step_s),
    .dividend  (a_mag_s),
    .divisor   (b_mag_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // FSM next-state, HI/LO update and handshake outputs.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    prod_d     = prod_q;
    a_d        = a_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    div_load_s = 1'b0;
    div_step_s = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op_s)
              MTHI: hi_d = a;
              MTLO: lo_d = a;
              MULT, MULTU: begin
                prod_d  = prod_full_s[2*WIDTH-1:0];
                count_d = CNT_W'(MUL_LAT - 1);
                state_d = ST_MUL;
              end
              DIV, DIVU: begin
                div_load_s = 1'b1;
                neg_quo_d  = is_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_d  = is_signed_s & a[WIDTH-1];
                div_zero_d = (b == {WIDTH{1'b0}});
                a_d        = a;
                count_d    = CNT_W'(WIDTH - 1);
                state_d    = ST_DIV;
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (count_q == {CNT_W{1'b0}}) begin
            {hi_d, lo_d} = prod_q;
            done_d       = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        ST_DIV: begin
          div_step_s = 1'b1;
          if (count_q == {CNT_W{1'b0}}) begin
            state_d = ST_FIX;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (div_zero_q) begin
            lo_d = {WIDTH{1'b1}};
            hi_d = a_q;
          end else begin
            lo_d = lo_fix_s;
            hi_d = hi_fix_s;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, HI/LO and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= {CNT_W{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      prod_q     <= {(2*WIDTH){1'b0}};
      a_q        <= {WIDTH{1'b0}};
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      prod_q     <= prod_d;
      a_q        <= a_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference result as {hi, lo}, computed with plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    case (o)
      3'd0: begin sp = longint'($signed(x)) * longint'($signed(y)); return 64'(sp); end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; return up; end
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sx = x; sy = y;
        return {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      step();
      lat++;
    end
  endtask

  // Issue an op, check handshake, latency and result; returns in the done cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(o, x, y);
    check_eq({tag, " busy"}, 64'(busy), 64'd1);
    check_eq({tag, " done_low"}, 64'(done), 64'd0);
    wait_done(lat);
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " busy_fall"}, 64'(busy), 64'd0);
    check_eq({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    check_eq({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
  endtask

  initial begin
    int lat;
    logic seen_done;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    // Reset state
    repeat (3) step();
    check_eq("rst hi", 64'(hi), 64'd0);
    check_eq("rst lo", 64'(lo), 64'd0);
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done", 64'(done), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed test-plan vectors
    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, LAT);
    step();
    check_eq("mult done_pulse", 64'(done), 64'd0);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, LAT);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, W + 1);
    run_op("divu", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, W + 1);
    run_op("divu0", 3'd3, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, W + 1);
    run_op("div0s", 3'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, W + 1);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, W + 1);
    step();

    // MTHI then MTLO back to back
    op = 3'd4; a = 32'h1234; start = 1'b1;
    step();
    check_eq("mthi busy", 64'(busy), 64'd0);
    check_eq("mthi hi", 64'(hi), 64'h1234);
    op = 3'd5; a = 32'h5678;
    step();
    start = 1'b0;
    check_eq("mtlo busy", 64'(busy), 64'd0);
    check_eq("mtlo done", 64'(done), 64'd0);
    check_eq("mtlo hi", 64'(hi), 64'h1234);
    check_eq("mtlo lo", 64'(lo), 64'h5678);

    // Start while busy is ignored
    issue(3'd3, 32'd100, 32'd7);
    repeat (5) step();
    op = 3'd4; a = 32'hDEAD; start = 1'b1;
    step();
    start = 1'b0;
    check_eq("intrude busy", 64'(busy), 64'd1);
    wait_done(lat);
    check_eq("intrude latency", 64'(lat + 6), 64'(W + 1));
    check_eq("intrude hi", 64'(hi), 64'd2);
    check_eq("intrude lo", 64'(lo), 64'd14);
    step();

    // Flush during DIV
    issue(3'd4, 32'hAA, 32'd0);
    issue(3'd5, 32'hAA, 32'd0);
    issue(3'd2, 32'd1000, 32'd3);
    repeat (8) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush busy", 64'(busy), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      step();
    end
    check_eq("flush no_done", 64'(seen_done), 64'd0);
    check_eq("flush hi", 64'(hi), 64'hAA);
    check_eq("flush lo", 64'(lo), 64'hAA);

    // Flush wins over MUL completion in the same cycle
    issue(3'd0, 32'd3, 32'd3);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flushc done", 64'(done), 64'd0);
    check_eq("flushc busy", 64'(busy), 64'd0);
    check_eq("flushc lo", 64'(lo), 64'hAA);

    // Flush with start in IDLE drops the start
    op = 3'd4; a = 32'h55; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check_eq("flush_start hi", 64'(hi), 64'hAA);
    check_eq("flush_start busy", 64'(busy), 64'd0);

    // Undefined op codes are no-ops
    issue(3'd6, 32'h1, 32'h2);
    check_eq("nop6 busy", 64'(busy), 64'd0);
    issue(3'd7, 32'h1, 32'h2);
    check_eq("nop7 hi", 64'(hi), 64'hAA);
    check_eq("nop7 lo", 64'(lo), 64'hAA);

    // Asynchronous reset mid-DIV
    issue(3'd4, 32'h77, 32'd0);
    issue(3'd2, 32'd9, 32'd2);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst hi", 64'(hi), 64'd0);
    check_eq("arst lo", 64'(lo), 64'd0);
    check_eq("arst busy", 64'(busy), 64'd0);
    check_eq("arst done", 64'(done), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op("post_rst multu", 3'd1, 32'd3, 32'd4, {32'd0, 32'd12}, LAT);

    // Randomized ops, issued back to back in the done cycle
    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(0, 5));
      if (i % 13 == 5) r_b = 32'd0;
      if (i % 17 == 3) begin r_op = 3'd2; r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
      run_op($sformatf("rand%0d", i), r_op, r_a, r_b, ref_result(r_op, r_a, r_b),
             (r_op < 3'd2) ? LAT : W + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
